cache_sa_ctrl: RTL
==================

Name: cache_sa_ctrl

Overview:
Parametrised N-way set-associative cache with its own controller, and the successor to the direct-mapped cache storage block. It adds hit detection, pseudo-LRU replacement, block refill from memory, write-through/no-write-allocate stores and a sequenced invalidate-all flush. It sits between the CPU load/store port and the word-addressed memory bus.

Parameters:
DATA_W, 32, word width in bits
INDEX_W, 5, set index bits (2^INDEX_W sets)
TAG_W, 6, tag bits
WORDS_PER_BLOCK, 8, words per line; power of two, 2 or more; OFFS_W = log2(WORDS_PER_BLOCK)
WAYS, 2, associativity; allowed values are 1, 2 or 4
(derived) ADDR_W = TAG_W+INDEX_W+OFFS_W, word address {tag,index,offset}

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  request valid
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  store data
cpu_ready  out  1  request accepted when cpu_req & cpu_ready at a clock edge
cpu_rvalid  out  1  one-cycle pulse; load data valid
cpu_rdata  out  DATA_W  load data
flush  in  1  invalidate all lines
mem_req  out  1  memory access request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  access complete; mem_rdata sampled on this cycle
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (rst=0): takes effect immediately and asynchronously.
  - state goes to IDLE; all valid bits and PLRU bits clear.
  - All outputs are 0 except cpu_ready, which is 1 once rst=1 (combinational, see below).
  - Tag and data arrays are not reset.
- cpu_ready = (state==IDLE) & !flush. Flush wins over a simultaneous cpu_req; that request is not accepted.
- States: IDLE, LOOKUP, REFILL, WR_MEM, FLUSH.
- IDLE:
  - flush -> FLUSH.
  - Otherwise an accepted request captures we/addr/wdata -> LOOKUP.
- LOOKUP: hit = any way with valid & tag match. At most one way can match.
  - Load hit: cpu_rdata = matching word and cpu_rvalid=1, both registered on the edge leaving LOOKUP. PLRU is updated -> IDLE.
  - Load hit latency: accept edge N, rvalid high in cycle N+2.
  - Load miss: victim = lowest-index invalid way, else the PLRU way -> REFILL.
  - Store hit: write word into the hit way, update PLRU -> WR_MEM.
  - Store miss: no allocation, array unchanged -> WR_MEM.
- REFILL:
  - Fetch offsets 0..WORDS_PER_BLOCK-1 in order from {tag,index,0}; one mem_req per word, mem_we=0.
  - mem_addr stays stable while mem_req=1.
  - Each mem_ack writes mem_rdata into the victim way. mem_req drops for at least one cycle between words.
  - After the last word: set valid, write tag, update PLRU -> LOOKUP. The re-lookup hits and returns data.
- WR_MEM: mem_req=1, mem_we=1, mem_addr/mem_wdata = captured request until mem_ack -> IDLE. Stores produce no cpu_rvalid.
- FLUSH: clears the valid and PLRU bits of one set per cycle, sets 0..2^INDEX_W-1, then -> IDLE. cpu_ready=0 throughout.
- PLRU: tree of WAYS-1 bits per set (none for WAYS=1). On access, bits point away from the used way.
- mem_ack while mem_req=0 is ignored. flush asserted outside IDLE is ignored; it is level-sampled again in IDLE.

Optional Feature:
CACHE_STATS_EN
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Saturating counters, cleared by rst.
  - Incremented once per first LOOKUP of a request; the post-refill re-lookup is not counted.
  - Not cleared by flush.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg holds:
  - the state_t enum;
  - the PLRU width helper function;
  - the address field slice localparams/functions (tag/index/offset extraction).
- One sub-module, cache_plru: per-set PLRU bit update and victim selection, combinational, parametrised by WAYS.

Test Plan:
- Refill then hit: after reset, load 0x2A1A -> mem reads 0x2A18..0x2A1F; memory returns 0x1000+offset; cpu_rvalid with 0x1002. Then load 0x2A1D -> no mem_req, rdata 0x1005 in cycle N+2.
- Replacement (WAYS=2): fill set 3 with tags 0x2A and 0x15, load tag 0x2A, then load 0x3C1A (miss) -> tag 0x15 way evicted. Load 0x2A1A hits; load 0x151A misses.
- Store hit 0xDEADBEEF to 0x2A1A -> mem write addr 0x2A1A, data 0xDEADBEEF; following load returns 0xDEADBEEF with no refill. Store miss to 0x0F00 -> one mem write, no refill; next load of 0x0F00 misses.
- Flush pulse in IDLE with simultaneous cpu_req -> request not accepted; cpu_ready low for 32 cycles; then all previously hitting loads miss.
- mem_ack delayed 3 cycles per word -> mem_req/mem_addr stable. rst low during the 4th refill word -> mem_req 0 immediately; after release, load 0x2A1A misses.
- With CACHE_STATS_EN: run the first test's sequence -> hit_cnt=1, miss_cnt=1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache controller.
// The optional statistics counters are enabled with the macro CACHE_STATS_EN.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WR_MEM,
    FLUSH
  } state_t;

  localparam int ADDR_MAX_W = 32;

  // PLRU tree bits per set; a 1-way cache still stores one unused bit
  // so that the arrays never have zero width.
  function automatic int plru_w(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

  // Width of a way index.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Generic bit-field extraction from a zero-extended word address.
  function automatic logic [ADDR_MAX_W-1:0] addr_field(input logic [ADDR_MAX_W-1:0] a,
                                                       input int lsb, input int w);
    return (a >> lsb) & ((ADDR_MAX_W'(1) << w) - ADDR_MAX_W'(1));
  endfunction

  // Address layout is {tag, index, offset}.
  function automatic logic [ADDR_MAX_W-1:0] tag_of(input logic [ADDR_MAX_W-1:0] a,
                                                   input int offs_w, input int index_w);
    return a >> (offs_w + index_w);
  endfunction

  function automatic logic [ADDR_MAX_W-1:0] idx_of(input logic [ADDR_MAX_W-1:0] a,
                                                   input int offs_w, input int index_w);
    return addr_field(a, offs_w, index_w);
  endfunction

  function automatic logic [ADDR_MAX_W-1:0] off_of(input logic [ADDR_MAX_W-1:0] a,
                                                   input int offs_w);
    return addr_field(a, 0, offs_w);
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Tree pseudo-LRU for one set: next-state bits after an access and the
// victim way the current bits point at. Purely combinational.
// Encoding: each tree bit names the subtree to evict next; an access
// steers every bit on its path away from the used way.
module cache_plru import cache_pkg::*; #(
  parameter int WAYS = 2
) (
  input  logic [plru_w(WAYS)-1:0] bits_i,
  input  logic [way_w(WAYS)-1:0]  use_way_i,
  output logic [plru_w(WAYS)-1:0] bits_o,
  output logic [way_w(WAYS)-1:0]  victim_o
);

  if (WAYS == 4) begin : g_w4
    // bit0 picks the half, bit1 ways 0/1, bit2 ways 2/3
    always_comb begin
      bits_o    = bits_i;
      bits_o[0] = ~use_way_i[1];
      if (use_way_i[1]) bits_o[2] = ~use_way_i[0];
      else              bits_o[1] = ~use_way_i[0];
    end
    assign victim_o = bits_i[0] ? {1'b1, bits_i[2]} : {1'b0, bits_i[1]};
  end else if (WAYS == 2) begin : g_w2
    assign bits_o   = ~use_way_i;
    assign victim_o = bits_i;
  end else begin : g_w1
    assign bits_o   = bits_i;
    assign victim_o = '0;
  end

endmodule

// File: rtl/cache_sa_ctrl.sv
// N-way set-associative cache with controller: hit detect, PLRU replacement,
// block refill, write-through / no-write-allocate stores, sequenced flush.
// Define CACHE_STATS_EN to add saturating hit_cnt / miss_cnt outputs.
module cache_sa_ctrl import cache_pkg::*; #(
  parameter  int DATA_W          = 32,
  parameter  int INDEX_W         = 5,
  parameter  int TAG_W           = 6,
  parameter  int WORDS_PER_BLOCK = 8,
  parameter  int WAYS            = 2,
  localparam int OFFS_W          = $clog2(WORDS_PER_BLOCK),
  localparam int ADDR_W          = TAG_W + INDEX_W + OFFS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int SETS = 1 << INDEX_W;
  localparam int PW   = plru_w(WAYS);
  localparam int WW   = way_w(WAYS);
  localparam int LINES = SETS * WORDS_PER_BLOCK;
  localparam logic [OFFS_W-1:0]  LAST_WORD = OFFS_W'(WORDS_PER_BLOCK - 1);
  localparam logic [INDEX_W-1:0] LAST_SET  = INDEX_W'(SETS - 1);

  state_t state_q, state_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WW-1:0]     victim_q;
  logic [OFFS_W-1:0] word_q;
  logic              gap_q;     // forces mem_req low for a cycle between refill words
  logic [INDEX_W-1:0] fidx_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [PW-1:0]     plru_q  [SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [DATA_W-1:0] data_q  [WAYS][LINES];

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [OFFS_W-1:0]  req_off;

  assign req_tag = TAG_W'(tag_of(ADDR_MAX_W'(addr_q), OFFS_W, INDEX_W));
  assign req_idx = INDEX_W'(idx_of(ADDR_MAX_W'(addr_q), OFFS_W, INDEX_W));
  assign req_off = OFFS_W'(off_of(ADDR_MAX_W'(addr_q), OFFS_W));

  logic [WAYS-1:0] hit_vec, inv_vec;
  logic            hit;
  logic [WW-1:0]   hit_way, free_way;
  logic [DATA_W-1:0] hit_word;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign hit_vec[w] = valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag);
    assign inv_vec[w] = !valid_q[req_idx][w];
  end

  // Encode the (single) hitting way and the lowest-index invalid way
  always_comb begin
    hit      = |hit_vec;
    hit_way  = '0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way  = WW'(w);
      if (inv_vec[w]) free_way = WW'(w);
    end
  end

  assign hit_word = data_q[hit_way][{req_idx, req_off}];

  logic [WW-1:0] use_way, plru_vic;
  logic [PW-1:0] plru_upd;

  // During refill the touched way is the victim, otherwise the hit way
  assign use_way = (state_q == REFILL) ? victim_q : hit_way;

  cache_plru #(.WAYS(WAYS)) u_plru (
    .bits_i   (plru_q[req_idx]),
    .use_way_i(use_way),
    .bits_o   (plru_upd),
    .victim_o (plru_vic)
  );

  logic refill_ack, refill_done;
  assign refill_ack  = (state_q == REFILL) && !gap_q && mem_ack;
  assign refill_done = refill_ack && (word_q == LAST_WORD);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush) state_d = FLUSH;
               else if (cpu_req) state_d = LOOKUP;
      LOOKUP:  if (we_q) state_d = WR_MEM;
               else state_d = hit ? IDLE : REFILL;
      REFILL:  if (refill_done) state_d = LOOKUP;
      WR_MEM:  if (mem_ack) state_d = IDLE;
      FLUSH:   if (fidx_q == LAST_SET) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, request capture, valid and PLRU bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      victim_q <= '0;
      word_q   <= '0;
      gap_q    <= 1'b0;
      fidx_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          fidx_q <= '0;
          if (cpu_ready && cpu_req) begin
            we_q    <= cpu_we;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
          end
        end
        LOOKUP: begin
          if (hit) begin
            plru_q[req_idx] <= plru_upd;
            if (!we_q) begin
              rvalid_q <= 1'b1;
              rdata_q  <= hit_word;
            end
          end else if (!we_q) begin
            victim_q <= (|inv_vec) ? free_way : plru_vic;
            word_q   <= '0;
            gap_q    <= 1'b0;
          end
        end
        REFILL: begin
          if (gap_q) begin
            gap_q <= 1'b0;
          end else if (mem_ack) begin
            gap_q  <= 1'b1;
            word_q <= word_q + 1'b1;
            if (word_q == LAST_WORD) begin
              valid_q[req_idx][victim_q] <= 1'b1;
              plru_q[req_idx]            <= plru_upd;
            end
          end
        end
        FLUSH: begin
          valid_q[fidx_q] <= '0;
          plru_q[fidx_q]  <= '0;
          fidx_q          <= fidx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays: store hits and refill words; never reset
  always_ff @(posedge clk) begin
    if (state_q == LOOKUP && hit && we_q)
      data_q[hit_way][{req_idx, req_off}] <= wdata_q;
    if (refill_ack) begin
      data_q[victim_q][{req_idx, word_q}] <= mem_rdata;
      if (word_q == LAST_WORD) tag_q[victim_q][req_idx] <= req_tag;
    end
  end

  assign cpu_ready  = rst && (state_q == IDLE) && !flush;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign mem_req    = ((state_q == REFILL) && !gap_q) || (state_q == WR_MEM);
  assign mem_we     = (state_q == WR_MEM);
  assign mem_wdata  = (state_q == WR_MEM) ? wdata_q : '0;

  // Memory address: block fetch during refill, captured address for stores
  always_comb begin
    mem_addr = '0;
    if (state_q == REFILL)      mem_addr = {req_tag, req_idx, word_q};
    else if (state_q == WR_MEM) mem_addr = addr_q;
  end

`ifdef CACHE_STATS_EN
  logic        relook_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Count only the first lookup of each request; saturate at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      relook_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state_q == REFILL && state_d == LOOKUP) relook_q <= 1'b1;
      else if (state_q == LOOKUP)                 relook_q <= 1'b0;
      if (state_q == LOOKUP && !relook_q) begin
        if (hit) begin
          if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
        end else if (miss_cnt_q != '1) begin
          miss_cnt_q <= miss_cnt_q + 32'd1;
        end
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
